shared_reg_arbiter: RTL and testbench

Round-robin arbiter and write sequencer for one shared 16-bit storage register. It accepts write requests from up to four requesters and grants the register to one requester at a time. It captures the granted requester's data into the register and acknowledges completion. It sits between the requesting datapath units and the storage element they share; all writes to that register go through this block.

---
 rtl/shared_reg_arbiter.sv | 117 +++++++++++
 tb/tb_shared_reg_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for a single shared storage register.
// Up to N requesters compete; each granted write is captured and acknowledged in three cycles.
module shared_reg_arbiter #(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int IDW   = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] wdata,
    input  logic               clr,
    output logic [N-1:0]       gnt,
    output logic               ack,
    output logic [WIDTH-1:0]   q,
    output logic [IDW-1:0]     owner,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_ACK
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_win;
    logic [N-1:0]     r_gnt;
    logic             r_ack;
    logic [WIDTH-1:0] r_q;
    logic [IDW-1:0]   r_owner;
    logic             r_busy;

    logic             w_found;
    logic [IDW-1:0]   w_winIdx;
    logic [N-1:0]     w_winOneHot;
    logic [IDW-1:0]   w_ptrNext;
    logic [WIDTH-1:0] w_wdataSel;

    // Search upward from the round-robin pointer, wrapping, for the first active request.
    always_comb begin
        w_found  = 1'b0;
        w_winIdx = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && req[(int'(r_ptr) + k) % N]) begin
                w_found  = 1'b1;
                w_winIdx = IDW'((int'(r_ptr) + k) % N);
            end
        end
    end

    assign w_winOneHot = N'(1) << w_winIdx;
    assign w_ptrNext   = (r_win == IDW'(N - 1)) ? '0 : r_win + 1'b1;
    assign w_wdataSel  = wdata[int'(r_win) * WIDTH +: WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_gnt   <= '0;
            r_ack   <= 1'b0;
            r_q     <= '0;
            r_owner <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_win   <= w_winIdx;
                        r_gnt   <= w_winOneHot;
                        r_busy  <= 1'b1;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_gnt <= '0;
                    if (req[r_win]) begin
                        // A clear on this edge discards the data but the transaction still completes.
                        if (!clr) begin
                            r_q     <= w_wdataSel;
                            r_owner <= r_win;
                        end
                        r_ack   <= 1'b1;
                        r_ptr   <= w_ptrNext;
                        r_state <= S_ACK;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_ACK: begin
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_gnt   <= '0;
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
            if (clr) begin
                r_q <= '0;
            end
        end
    end

    assign gnt   = r_gnt;
    assign ack   = r_ack;
    assign q     = r_q;
    assign owner = r_owner;
    assign busy  = r_busy;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter: directed request patterns push expected grants
// and writes into queues, and a negedge monitor pops and compares them as the DUT produces them.
module tb_shared_reg_arbiter;

    typedef struct {
        logic [3:0] gnt;
        int         cyc;
    } gntExp_t;

    typedef struct {
        logic [15:0] q;
        logic [1:0]  owner;
        int          cyc;
    } wrExp_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] wdata;
    logic        clr;
    logic [3:0]  gnt;
    logic        ack;
    logic [15:0] q;
    logic [1:0]  owner;
    logic        busy;

    logic [15:0] data [4];
    gntExp_t     gntQ[$];
    wrExp_t      wrQ[$];
    int          expWin[$];
    int          cycle = 0;
    int          checks = 0;
    int          failures = 0;

    assign wdata = {data[3], data[2], data[1], data[0]};

    shared_reg_arbiter #(.WIDTH(16), .N(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .wdata (wdata),
        .clr   (clr),
        .gnt   (gnt),
        .ack   (ack),
        .q     (q),
        .owner (owner),
        .busy  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Holds reqMask for nTx back-to-back transactions whose winners are queued in expWin.
    task automatic applyStimulus(input logic [3:0] reqMask, input int nTx);
        int c;
        int w;
        c   = cycle;
        req = reqMask;
        for (int k = 0; k < nTx; k++) begin
            w = expWin.pop_front();
            gntQ.push_back('{4'(1) << w, c + 1 + 3 * k});
            wrQ.push_back('{data[w], 2'(w), c + 2 + 3 * k});
        end
        repeat (3 * nTx - 1) tick();
        req = 4'b0000;
        tick();
    endtask

    // Monitor: flags missed, unexpected and wrong grants/acks.
    always @(negedge clk) begin
        while (gntQ.size() > 0 && gntQ[0].cyc < cycle) begin
            checks++;
            failures++;
            $display("[TB] FAIL grant_missed: actual=none expected gnt=%b at cycle %0d", gntQ[0].gnt, gntQ[0].cyc);
            void'(gntQ.pop_front());
        end
        while (wrQ.size() > 0 && wrQ[0].cyc < cycle) begin
            checks++;
            failures++;
            $display("[TB] FAIL ack_missed: actual=none expected q=%h owner=%0d at cycle %0d", wrQ[0].q, wrQ[0].owner, wrQ[0].cyc);
            void'(wrQ.pop_front());
        end
        if (gnt != 4'b0000) begin
            checks++;
            if (gntQ.size() == 0 || gntQ[0].cyc != cycle) begin
                failures++;
                $display("[TB] FAIL grant_unexpected: actual gnt=%b at cycle %0d expected no grant", gnt, cycle);
            end else begin
                if (gnt !== gntQ[0].gnt) begin
                    failures++;
                    $display("[TB] FAIL grant_value: actual gnt=%b expected gnt=%b at cycle %0d", gnt, gntQ[0].gnt, cycle);
                end
                void'(gntQ.pop_front());
            end
        end
        if (ack) begin
            checks++;
            if (wrQ.size() == 0 || wrQ[0].cyc != cycle) begin
                failures++;
                $display("[TB] FAIL ack_unexpected: actual ack=1 q=%h at cycle %0d expected no ack", q, cycle);
            end else begin
                if (q !== wrQ[0].q || owner !== wrQ[0].owner) begin
                    failures++;
                    $display("[TB] FAIL write_value: actual q=%h owner=%0d expected q=%h owner=%0d at cycle %0d",
                             q, owner, wrQ[0].q, wrQ[0].owner, cycle);
                end
                void'(wrQ.pop_front());
            end
        end
    end

    initial begin
        int c;
        rst_n   = 1'b0;
        req     = 4'b0000;
        clr     = 1'b0;
        data[0] = 16'h1111;
        data[1] = 16'h2222;
        data[2] = 16'h3333;
        data[3] = 16'h4444;
        repeat (2) tick();
        checkOutput("reset_gnt",   16'(gnt),   16'h0000);
        checkOutput("reset_ack",   16'(ack),   16'h0000);
        checkOutput("reset_q",     q,          16'h0000);
        checkOutput("reset_owner", 16'(owner), 16'h0000);
        checkOutput("reset_busy",  16'(busy),  16'h0000);
        rst_n = 1'b1;
        tick();

        // Round-robin with all requests held: 0,1,2,3,0 leaves the pointer at 1.
        expWin = '{0, 1, 2, 3, 0};
        applyStimulus(4'b1111, 5);

        // Abort: requester 1 drops its request while granted.
        c   = cycle;
        req = 4'b0010;
        gntQ.push_back('{4'b0010, c + 1});
        tick();
        checkOutput("abort_busy_grant", 16'(busy), 16'h0001);
        req = 4'b0000;
        tick();
        checkOutput("abort_busy_idle", 16'(busy), 16'h0000);
        checkOutput("abort_ack",       16'(ack),  16'h0000);
        checkOutput("abort_q",         q,         16'h1111);
        tick();
        checkOutput("abort_ack_late",  16'(ack),  16'h0000);

        // Clear collides with the capture of requester 1; pointer unchanged by the abort.
        data[1] = 16'h1234;
        c       = cycle;
        req     = 4'b1111;
        gntQ.push_back('{4'b0010, c + 1});
        wrQ.push_back('{16'h0000, 2'd0, c + 2});
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        req = 4'b0000;
        checkOutput("clr_q",     q,          16'h0000);
        checkOutput("clr_owner", 16'(owner), 16'h0000);
        tick();

        // Pointer advanced past 1 despite the discarded data, so requester 2 wins.
        expWin = '{2};
        applyStimulus(4'b1111, 1);

        // Wrap and skip from pointer 3.
        expWin = '{0, 1};
        applyStimulus(4'b0011, 2);

        // Single requester with busy timing.
        data[2] = 16'hBEEF;
        c       = cycle;
        req     = 4'b0100;
        gntQ.push_back('{4'b0100, c + 1});
        wrQ.push_back('{16'hBEEF, 2'd2, c + 2});
        tick();
        checkOutput("single_busy_grant", 16'(busy), 16'h0001);
        tick();
        checkOutput("single_busy_ack",   16'(busy), 16'h0001);
        req = 4'b0000;
        tick();
        checkOutput("single_busy_idle",  16'(busy),  16'h0000);
        checkOutput("single_q_hold",     q,          16'hBEEF);
        checkOutput("single_owner_hold", 16'(owner), 16'h0002);

        // Reset asserted mid-grant.
        req = 4'b0001;
        tick();
        checkOutput("pre_reset_gnt", 16'(gnt), 16'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_gnt",   16'(gnt),   16'h0000);
        checkOutput("midrst_ack",   16'(ack),   16'h0000);
        checkOutput("midrst_q",     q,          16'h0000);
        checkOutput("midrst_owner", 16'(owner), 16'h0000);
        checkOutput("midrst_busy",  16'(busy),  16'h0000);
        tick();
        tick();
        rst_n = 1'b1;
        c     = cycle;
        gntQ.push_back('{4'b0001, c + 1});
        wrQ.push_back('{16'h1111, 2'd0, c + 2});
        tick();
        tick();
        req = 4'b0000;
        tick();

        repeat (3) tick();
        checkOutput("grant_queue_empty", 16'(gntQ.size()), 16'h0000);
        checkOutput("write_queue_empty", 16'(wrQ.size()),  16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
